// File: rtl/mdu_pkg.sv
// ============================================================================
//  mdu_pkg
//  Shared encodings, FSM state type and constants for the iterative MDU.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    localparam int          MDU_ITER    = 32;
    localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of a signed operand; 0x80000000 maps to itself as unsigned.
    function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iterative_if.sv
// ============================================================================
//  mdu_iterative_if
//  Request/response bundle between the EX stage and the iterative MDU.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface mdu_iterative_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hi_we;
    logic        lo_we;

    modport master (
        output start, op, rs_val, rt_val, abort,
        input  busy, done, hi, lo, hi_we, lo_we
    );

    modport slave (
        input  start, op, rs_val, rt_val, abort,
        output busy, done, hi, lo, hi_we, lo_we
    );
endinterface

`default_nettype wire

// File: rtl/mdu_iter_step.sv
// ============================================================================
//  mdu_iter_step
//  One combinational iteration: shift-add multiply or restoring divide step.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_iter_step (
    input  wire logic        div_mode_i,
    input  wire logic [63:0] acc_i,
    input  wire logic [31:0] rem_i,
    input  wire logic [31:0] opnd_i,
    output logic      [63:0] acc_o,
    output logic      [31:0] rem_o
);

    logic [32:0] w_sum;
    logic [32:0] w_shifted;
    logic        w_fits;

    always_comb begin
        acc_o     = acc_i;
        rem_o     = rem_i;
        w_sum     = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
        w_shifted = {rem_i, acc_i[31]};
        w_fits    = (w_shifted >= {1'b0, opnd_i});
        if (!div_mode_i) begin
            acc_o = {w_sum, acc_i[31:1]};
        end else begin
            // The divisor magnitude bounds the remainder, so 32 bits hold it after the step.
            rem_o = w_fits ? 32'(w_shifted - {1'b0, opnd_i}) : w_shifted[31:0];
            acc_o = {acc_i[63:32], acc_i[30:0], w_fits};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_iterative.sv
// ============================================================================
//  mdu_iterative
//  Iterative MULT/MULTU/DIV/DIVU unit; MDU_EARLY_OUT_EN enables zero early-out.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int ITER = MDU_ITER
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mdu_iterative_if.slave   bus
);

    localparam int CNT_W = $clog2(ITER + 1);

    mdu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              div_q;
    logic              sgn_q;
    logic              neg_q;
    logic              rneg_q;
    logic              div0_q;
    logic              zero_q;
    logic [63:0]       acc_q;
    logic [31:0]       rem_q;
    logic [31:0]       opnd_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;

    logic [63:0]       acc_d;
    logic [31:0]       rem_d;
    logic [63:0]       prod_d;
    logic [31:0]       hi_d;
    logic [31:0]       lo_d;

    logic              w_signed;
    logic              w_div;
    logic [31:0]       w_mag_rs;
    logic [31:0]       w_mag_rt;
    logic              w_early;

    assign w_signed = ~bus.op[0];
    assign w_div    = bus.op[1];
    assign w_mag_rs = mdu_abs(bus.rs_val, w_signed);
    assign w_mag_rt = mdu_abs(bus.rt_val, w_signed);

`ifdef MDU_EARLY_OUT_EN
    assign w_early = w_div ? ((bus.rs_val == 32'd0) && (bus.rt_val != 32'd0))
                           : ((bus.rs_val == 32'd0) || (bus.rt_val == 32'd0));
`else
    assign w_early = 1'b0;
`endif

    mdu_iter_step u_step (
        .div_mode_i (div_q),
        .acc_i      (acc_q),
        .rem_i      (rem_q),
        .opnd_i     (opnd_q),
        .acc_o      (acc_d),
        .rem_o      (rem_d)
    );

    // A zero divisor leaves remainder = |dividend|, so sign fixing restores rs_val on HI.
    always_comb begin
        prod_d = (sgn_q && neg_q) ? (64'd0 - acc_q) : acc_q;
        hi_d   = prod_d[63:32];
        lo_d   = prod_d[31:0];
        if (div_q) begin
            hi_d = (sgn_q && rneg_q) ? (32'd0 - rem_q) : rem_q;
            lo_d = div0_q ? MDU_DIV0_LO
                 : ((sgn_q && neg_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
        end
        if (zero_q) begin
            hi_d = 32'd0;
            lo_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            zero_q  <= 1'b0;
            acc_q   <= '0;
            rem_q   <= '0;
            opnd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        acc_q   <= {32'd0, (w_div ? w_mag_rs : w_mag_rt)};
                        opnd_q  <= w_div ? w_mag_rt : w_mag_rs;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        div_q   <= w_div;
                        sgn_q   <= w_signed;
                        neg_q   <= bus.rs_val[31] ^ bus.rt_val[31];
                        rneg_q  <= bus.rs_val[31];
                        div0_q  <= w_div && (bus.rt_val == 32'd0);
                        zero_q  <= w_early;
                        busy_q  <= 1'b1;
                        state_q <= w_early ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ITER - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (!bus.abort) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi_we = done_q;
    assign bus.lo_we = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
// ============================================================================
//  tb_mdu_iterative
//  Directed, table-driven bench for mdu_iterative (MDU_EARLY_OUT_EN aware).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mdu_iterative;
    import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif
    localparam int FULL_LAT = 34;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mdu_iterative_if bus ();

    mdu_iterative #(.ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        cycle();
        bus.start  = 1'b0;
        bus.op     = ~op;
        bus.rs_val = 32'hDEAD_BEEF;
        bus.rt_val = 32'h0BAD_F00D;
    endtask

    // Returns in the done cycle so a caller may launch back-to-back.
    task automatic wait_done(input string name, input int exp_lat,
                             input logic [31:0] eh, input logic [31:0] el, input int already);
        int  n;
        bit  busy_ok;
        n = already;
        busy_ok = 1'b1;
        while (n < 100) begin
            if (n > already || already == 0) begin
                if (bus.done) break;
            end
            cycle();
            n++;
            if (bus.done) break;
            if (!bus.busy || bus.hi_we || bus.lo_we) busy_ok = 1'b0;
        end
        check({name, ".latency"}, 64'(n), 64'(exp_lat));
        check({name, ".hi"}, 64'(bus.hi), 64'(eh));
        check({name, ".lo"}, 64'(bus.lo), 64'(el));
        check({name, ".busy_we"}, {61'd0, bus.busy, bus.hi_we, bus.lo_we}, 64'b011);
        check({name, ".busy_during"}, 64'(busy_ok), 64'd1);
    endtask

    task automatic watch_no_done(input string name, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            cycle();
            if (bus.done || bus.hi_we || bus.lo_we || bus.busy) seen++;
        end
        check({name, ".quiet"}, 64'(seen), 64'd0);
    endtask

    vec_t vecs[13];

    initial begin
        errors = 0;
        checks = 0;
        vecs[0]  = '{"multu_max",  MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, FULL_LAT};
        vecs[1]  = '{"mult_m3x7",  MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, FULL_LAT};
        vecs[2]  = '{"mult_minsq", MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, FULL_LAT};
        vecs[3]  = '{"div_m7d2",   MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, FULL_LAT};
        vecs[4]  = '{"divu_100d7", MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       FULL_LAT};
        vecs[5]  = '{"div_ovf",    MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, FULL_LAT};
        vecs[6]  = '{"div_by0",    MDU_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, FULL_LAT};
        vecs[7]  = '{"div_neg_by0",MDU_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, FULL_LAT};
        vecs[8]  = '{"divu_big",   MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, FULL_LAT};
        vecs[9]  = '{"div_7dm2",   MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, FULL_LAT};
        vecs[10] = '{"mult_neg1",  MDU_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, FULL_LAT};
        vecs[11] = '{"mult_0x5",   MDU_MULT,  32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, EO_LAT};
        vecs[12] = '{"divu_0d0",   MDU_DIVU,  32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, FULL_LAT};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.op     = 2'b00;
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (3) cycle();
        reset = 1'b0;
        check("reset.flags", {60'd0, bus.busy, bus.done, bus.hi_we, bus.lo_we}, 64'd0);
        check("reset.hilo", {bus.hi, bus.lo}, 64'd0);

        // Each launch happens in the previous done cycle: back-to-back throughput.
        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_done(vecs[i].name, vecs[i].exp_lat, vecs[i].exp_hi, vecs[i].exp_lo, 1);
        end
        cycle();
        check("strobe_one_cycle", {61'd0, bus.done, bus.hi_we, bus.lo_we}, 64'd0);

        `ifdef MDU_EARLY_OUT_EN
        launch(MDU_DIV, 32'd0, 32'd3);
        wait_done("div_0d3", EO_LAT, 32'd0, 32'd0, 1);
        cycle();
        `endif

        // Start while busy is ignored.
        launch(MDU_MULTU, 32'd6, 32'd7);
        repeat (4) cycle();
        launch(MDU_MULTU, 32'd9, 32'd9);
        wait_done("busy_ignore", FULL_LAT, 32'd0, 32'd42, 6);
        cycle();

        // Abort mid-calculation.
        launch(MDU_DIVU, 32'd100, 32'd7);
        repeat (9) cycle();
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        check("abort.busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        watch_no_done("abort", 40);
        check("abort.hilo_kept", {bus.hi, bus.lo}, {32'd0, 32'd42});

        // Abort together with start in IDLE.
        bus.abort = 1'b1;
        launch(MDU_MULTU, 32'd3, 32'd3);
        bus.abort = 1'b0;
        check("abort_start.busy", 64'(bus.busy), 64'd0);
        watch_no_done("abort_start", 40);

        // Reset mid-divide.
        launch(MDU_DIVU, 32'hFFFFFFFF, 32'd3);
        repeat (19) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midreset.flags", {60'd0, bus.busy, bus.done, bus.hi_we, bus.lo_we}, 64'd0);
        check("midreset.hilo", {bus.hi, bus.lo}, 64'd0);
        watch_no_done("midreset", 40);
        launch(MDU_MULTU, 32'd6, 32'd7);
        wait_done("after_reset", FULL_LAT, 32'd0, 32'd42, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_iterative.md
# mdu_iterative

Iterative multiply/divide unit for the MIPS pipeline's EX stage. Executes MULT, MULTU, DIV and DIVU over a fixed number of cycles and produces the 32-bit HI and LO results with one-cycle write strobes. These strobes feed the HI and LO architectural registers directly downstream. A busy flag lets hazard logic stall later MFHI/MFLO and MDU instructions.

## Interface
- ITER, default 32: iteration count; equals the operand width.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  input  32  multiplicand or dividend.
- rt_val  input  32  multiplier or divisor.
- abort  input  1  pipeline flush; cancels the operation in flight.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse; hi/lo are valid in that cycle.
- hi  output  32  product[63:32] or remainder.
- lo  output  32  product[31:0] or quotient.
- hi_we, lo_we  output  1 each  write strobes to HI and LO; equal to done.

## Operation
- States are IDLE, CALC and FIX.
- IDLE:
  - start=1 and abort=0 latches op and operand magnitudes (abs value when signed), clears the count, and goes to CALC.
  - It also records the result signs: product sign = rs[31]^rt[31]; quotient sign = rs[31]^rt[31]; remainder sign = rs[31].
- CALC:
  - Each cycle performs one step:
    - multiply: shift-add on a 64-bit accumulator;
    - divide: restoring shift-subtract, with a 33-bit partial remainder.
  - After ITER steps, go to FIX.
- FIX:
  - Apply two's-complement sign correction for signed ops and register the results into hi/lo.
  - Pulse done, hi_we and lo_we, then return to IDLE.
- Arithmetic rules:
  - Magnitudes are 32-bit unsigned, so |0x80000000| = 0x80000000 is correct.
  - Products are the full 64 bits.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / -1 (signed) gives lo=0x80000000, hi=0.
- Divide by zero:
  - Detected at acceptance; the unit still runs full latency.
  - Result is hi=rs_val, lo=0xFFFFFFFF, for both signed and unsigned.
- start while busy is ignored; no queueing.
- abort:
  - In CALC or FIX, abort goes to IDLE the next edge with no done and no write strobes; hi/lo keep their previous values.
  - abort has priority over start in the same cycle.
- Reset:
  - State IDLE; busy=0, done=0, hi_we=0, lo_we=0, hi=0, lo=0.
  - Reset mid-operation discards the operation.
- hi/lo hold their last result until the next done.

## Timing
- Edge E0 accepts start. busy is high after E0.
- Edges E1..E_ITER perform the iterations. Edge E_ITER+1 registers the results.
- done, hi_we, lo_we and valid hi/lo appear in the cycle after E_ITER+1, i.e. 34 cycles after acceptance for ITER=32.
- busy falls in the same cycle done rises.
- A new start is accepted in the done cycle, giving back-to-back throughput of one op per 34 cycles.
- Inputs rs_val, rt_val and op are sampled only at E0 and may change afterwards.

## Configuration
- MDU_EARLY_OUT_EN defined:
  - Trigger: a multiply with either operand zero, or a divide with dividend zero and divisor non-zero.
  - Behaviour: skip CALC and go IDLE→FIX, so done comes 2 cycles after acceptance with hi=lo=0.
- MDU_EARLY_OUT_EN undefined: every operation takes full latency.
- Divide by zero never early-outs in either build.

## Structure
- Package mdu_pkg holds:
  - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU);
  - the state enum (IDLE, CALC, FIX);
  - the ITER default and the divide-by-zero LO constant 32'hFFFFFFFF.
- Sub-module mdu_iter_step is a purely combinational single-iteration datapath: one multiply shift-add step or one divide shift-subtract step, selected by a mode bit.
- The top level holds the FSM, counter, operand and sign registers, and the output registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after start, hi_we=lo_we=1 for one cycle.
- MULT −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2. DIV 0x80000000 / −1 → lo=0x80000000, hi=0.
- DIV 0x12345678 / 0 → hi=0x12345678, lo=0xFFFFFFFF, full latency. With MDU_EARLY_OUT_EN, MULT 0 × 5 gives done 2 cycles after start with hi=lo=0.
- Busy and abort handling:
  - A second start at cycle 5 with different operands is ignored; the first result is returned.
  - abort at cycle 10 gives no done or strobes, busy low next cycle, and hi/lo unchanged.
  - abort together with start in IDLE → nothing accepted.
- reset asserted at cycle 20 of a DIVU → next cycle all outputs are 0 and state is IDLE. A subsequent MULTU 6 × 7 returns lo=42, hi=0.
